// File: rtl/sdram_ch3_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_ch3_arbiter : SDRAM channel 3 arbiter between ROM loader and F2 CPU
// Revision: 1.0
// ============================================================================
module sdram_ch3_arbiter #(
    parameter int ADDR_W        = 27,
    parameter int TIMEOUT       = 4096,
    parameter int RESYNC_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              loader_busy,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [15:0]       ldr_din,
    input  logic [1:0]        ldr_be,
    input  logic              ldr_rnw,
    input  logic              ldr_req,
    output logic              ldr_ack,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    input  logic [1:0]        cpu_be,
    input  logic              cpu_rnw,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [63:0]       cpu_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    output logic              mem_rnw,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [63:0]       mem_q,
    output logic              timeout_err
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RS_W = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [RS_W-1:0] RS_LAST = RS_W'((RESYNC_CYCLES > 0) ? RESYNC_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              mode, mode_nxt;
    logic [RS_W-1:0]   rs_cnt, rs_cnt_nxt;
    logic [WD_W-1:0]   wdog, wdog_nxt;
    logic              ldr_ack_nxt, cpu_ack_nxt, mem_req_nxt, mem_rnw_nxt, timeout_err_nxt;
    logic [63:0]       cpu_q_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [15:0]       mem_din_nxt;
    logic [1:0]        mem_be_nxt;

    logic ldr_pend, cpu_pend;
    assign ldr_pend = ldr_req ^ ldr_ack;
    assign cpu_pend = cpu_req ^ cpu_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RESYNC;
            mode        <= 1'b0;
            rs_cnt      <= '0;
            wdog        <= '0;
            ldr_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_q       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_be      <= '0;
            mem_rnw     <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            rs_cnt      <= rs_cnt_nxt;
            wdog        <= wdog_nxt;
            ldr_ack     <= ldr_ack_nxt;
            cpu_ack     <= cpu_ack_nxt;
            cpu_q       <= cpu_q_nxt;
            mem_req     <= mem_req_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_din     <= mem_din_nxt;
            mem_be      <= mem_be_nxt;
            mem_rnw     <= mem_rnw_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        mode_nxt        = mode;
        rs_cnt_nxt      = rs_cnt;
        wdog_nxt        = wdog;
        ldr_ack_nxt     = ldr_ack;
        cpu_ack_nxt     = cpu_ack;
        cpu_q_nxt       = cpu_q;
        mem_req_nxt     = mem_req;
        mem_addr_nxt    = mem_addr;
        mem_din_nxt     = mem_din;
        mem_be_nxt      = mem_be;
        mem_rnw_nxt     = mem_rnw;
        timeout_err_nxt = timeout_err;

        case (state)
            RESYNC: begin
                // Mirroring the ack swallows any stale memory handshake
                mem_req_nxt = mem_ack;
                if (rs_cnt == RS_LAST) begin
                    rs_cnt_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    rs_cnt_nxt = rs_cnt + 1'b1;
                end
            end

            IDLE: begin
                mode_nxt = loader_busy;
                if (loader_busy) begin
                    if (ldr_pend) begin
                        mem_addr_nxt = ldr_addr;
                        mem_din_nxt  = ldr_din;
                        mem_be_nxt   = ldr_be;
                        mem_rnw_nxt  = ldr_rnw;
                        mem_req_nxt  = ~mem_req;
                        wdog_nxt     = '0;
                        state_nxt    = WAIT;
                    end
                    if (cpu_pend)
                        cpu_ack_nxt = ~cpu_ack;
                end else begin
                    if (cpu_pend) begin
                        mem_addr_nxt = cpu_addr;
                        mem_din_nxt  = cpu_din;
                        mem_be_nxt   = cpu_be;
                        mem_rnw_nxt  = cpu_rnw;
                        mem_req_nxt  = ~mem_req;
                        wdog_nxt     = '0;
                        state_nxt    = WAIT;
                    end
                    if (ldr_pend)
                        ldr_ack_nxt = ~ldr_ack;
                end
            end

            WAIT: begin
                // mode was loaded at grant time and therefore names the owner
                if (mem_ack == mem_req) begin
                    if (!mode && mem_rnw)
                        cpu_q_nxt = mem_q;
                    if (mode)
                        ldr_ack_nxt = ~ldr_ack;
                    else
                        cpu_ack_nxt = ~cpu_ack;
                    state_nxt = IDLE;
                end else if ((TIMEOUT != 0) && (wdog == WD_LAST)) begin
                    timeout_err_nxt = 1'b1;
                    if (mode) begin
                        ldr_ack_nxt = ~ldr_ack;
                    end else begin
                        cpu_ack_nxt = ~cpu_ack;
                        cpu_q_nxt   = 64'hFFFF_FFFF_FFFF_FFFF;
                    end
                    rs_cnt_nxt = '0;
                    state_nxt  = RESYNC;
                end else if (wdog != {WD_W{1'b1}}) begin
                    wdog_nxt = wdog + 1'b1;
                end
            end

            default: begin
                rs_cnt_nxt = '0;
                state_nxt  = RESYNC;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_ch3_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_ch3_arbiter : directed self-checking bench for sdram_ch3_arbiter
// Revision: 1.0
// ============================================================================
module tb_sdram_ch3_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        loader_busy;
    logic [26:0] ldr_addr, cpu_addr, mem_addr;
    logic [15:0] ldr_din, cpu_din, mem_din;
    logic [1:0]  ldr_be, cpu_be, mem_be;
    logic        ldr_rnw, cpu_rnw, mem_rnw;
    logic        ldr_req, ldr_ack, cpu_req, cpu_ack, mem_req, mem_ack;
    logic [63:0] cpu_q, mem_q;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_ch3_arbiter #(
        .ADDR_W(27), .TIMEOUT(8), .RESYNC_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .loader_busy(loader_busy),
        .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_be(ldr_be), .ldr_rnw(ldr_rnw),
        .ldr_req(ldr_req), .ldr_ack(ldr_ack),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_be(cpu_be), .cpu_rnw(cpu_rnw),
        .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_rnw(mem_rnw),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_q(mem_q),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ack = 1'b1; loader_busy = 1'b0;
        ldr_req = 1'b0; cpu_req = 1'b0; mem_q = '0;
        ldr_addr = '0; ldr_din = '0; ldr_be = '0; ldr_rnw = 1'b1;
        cpu_addr = '0; cpu_din = '0; cpu_be = '0; cpu_rnw = 1'b1;
        tick(); tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
        checks++; if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0) begin errors++; $display("FAIL rst_acks got %0b%0b exp 00", cpu_ack, ldr_ack); end
        checks++; if (cpu_q !== 64'd0) begin errors++; $display("FAIL rst_cpu_q got %h exp 0", cpu_q); end
        checks++; if (mem_addr !== 27'd0 || mem_din !== 16'd0 || mem_be !== 2'd0) begin errors++; $display("FAIL rst_mem_fields got %h %h %b exp 0", mem_addr, mem_din, mem_be); end
        checks++; if (mem_rnw !== 1'b1) begin errors++; $display("FAIL rst_mem_rnw got %0b exp 1", mem_rnw); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %0b exp 0", timeout_err); end
        // CPU write pending through resync: must not be granted before edge 17
        cpu_addr = 27'h0000ABC; cpu_din = 16'h1234; cpu_be = 2'b11; cpu_rnw = 1'b0;
        cpu_req = 1'b1;
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL resync_mem_req edge %0d got %0b exp 1", i, mem_req); end
        end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL resync_cpu_ack got %0b exp 0", cpu_ack); end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_resync_grant mem_req got %0b exp 0", mem_req); end
        checks++; if (mem_addr !== 27'h0000ABC || mem_din !== 16'h1234 || mem_rnw !== 1'b0) begin errors++; $display("FAIL post_resync_fields got %h %h %0b exp abc 1234 0", mem_addr, mem_din, mem_rnw); end
        mem_ack = 1'b0; mem_q = 64'h5555_6666_7777_8888;
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL cpu_write_ack got %0b exp 1", cpu_ack); end
        checks++; if (cpu_q !== 64'd0) begin errors++; $display("FAIL cpu_write_q got %h exp 0", cpu_q); end
    endtask

    task automatic test_cpu_read();
        loader_busy = 1'b0; cpu_addr = 27'h0123456; cpu_rnw = 1'b1; cpu_be = 2'b11;
        cpu_req = ~cpu_req;
        tick();
        checks++; if (mem_addr !== 27'h0123456 || mem_rnw !== 1'b1) begin errors++; $display("FAIL cpu_rd_fields got %h %0b exp 0123456 1", mem_addr, mem_rnw); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL cpu_rd_mem_req got %0b exp 1", mem_req); end
        repeat (4) tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL cpu_rd_early_ack got %0b exp 1", cpu_ack); end
        mem_q = 64'hDEADBEEF_CAFEF00D; mem_ack = 1'b1;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_rd_ack got %0b exp 0", cpu_ack); end
        checks++; if (cpu_q !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL cpu_rd_q got %h exp deadbeefcafef00d", cpu_q); end
    endtask

    task automatic test_loader_write();
        loader_busy = 1'b1; ldr_addr = 27'h7654321; ldr_din = 16'hA55A; ldr_be = 2'b01; ldr_rnw = 1'b0;
        mem_q = 64'h1111_2222_3333_4444;
        ldr_req = ~ldr_req;
        tick();
        checks++; if (mem_din !== 16'hA55A || mem_be !== 2'b01 || mem_rnw !== 1'b0) begin errors++; $display("FAIL ldr_wr_fields got %h %b %0b exp a55a 01 0", mem_din, mem_be, mem_rnw); end
        checks++; if (mem_addr !== 27'h7654321 || mem_req !== 1'b0) begin errors++; $display("FAIL ldr_wr_grant got %h %0b exp 7654321 0", mem_addr, mem_req); end
        tick();
        checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL ldr_wr_early_ack got %0b exp 0", ldr_ack); end
        mem_ack = 1'b0;
        tick();
        checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL ldr_wr_ack got %0b exp 1", ldr_ack); end
        checks++; if (cpu_q !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL ldr_wr_cpu_q got %h exp deadbeefcafef00d", cpu_q); end
    endtask

    task automatic test_absorb();
        loader_busy = 1'b1;
        cpu_req = ~cpu_req;
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL absorb_cpu_ack got %0b exp 1", cpu_ack); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL absorb_mem_req got %0b exp 0", mem_req); end
        checks++; if (cpu_q !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL absorb_cpu_q got %h exp deadbeefcafef00d", cpu_q); end
        tick();
        checks++; if (cpu_ack !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL absorb_settle got %0b %0b exp 1 0", cpu_ack, mem_req); end
    endtask

    task automatic test_mode_switch();
        loader_busy = 1'b0; cpu_addr = 27'h0000100; cpu_rnw = 1'b1;
        cpu_req = ~cpu_req;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 27'h0000100) begin errors++; $display("FAIL ms_cpu_grant got %0b %h exp 1 100", mem_req, mem_addr); end
        loader_busy = 1'b1; ldr_addr = 27'h0000200; ldr_rnw = 1'b1;
        ldr_req = ~ldr_req;
        tick(); tick();
        checks++; if (mem_addr !== 27'h0000100 || ldr_ack !== 1'b1) begin errors++; $display("FAIL ms_hold got %h %0b exp 100 1", mem_addr, ldr_ack); end
        mem_q = 64'h0123_4567_89AB_CDEF; mem_ack = 1'b1;
        tick();
        checks++; if (cpu_ack !== 1'b0 || cpu_q !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ms_cpu_done got %0b %h exp 0 0123456789abcdef", cpu_ack, cpu_q); end
        checks++; if (ldr_ack !== 1'b1 || mem_addr !== 27'h0000100) begin errors++; $display("FAIL ms_ldr_not_yet got %0b %h exp 1 100", ldr_ack, mem_addr); end
        tick();
        checks++; if (mem_addr !== 27'h0000200 || mem_req !== 1'b0) begin errors++; $display("FAIL ms_ldr_grant got %h %0b exp 200 0", mem_addr, mem_req); end
        mem_q = 64'h9999_9999_9999_9999; mem_ack = 1'b0;
        tick();
        checks++; if (ldr_ack !== 1'b0 || cpu_q !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ms_ldr_done got %0b %h exp 0 0123456789abcdef", ldr_ack, cpu_q); end
    endtask

    task automatic test_timeout();
        loader_busy = 1'b0; cpu_addr = 27'h0000300; cpu_rnw = 1'b1;
        cpu_req = ~cpu_req;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_grant got %0b exp 1", mem_req); end
        repeat (7) tick();
        checks++; if (timeout_err !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL to_early got %0b %0b exp 0 0", timeout_err, cpu_ack); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %0b exp 1", timeout_err); end
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL to_cpu_ack got %0b exp 1", cpu_ack); end
        checks++; if (cpu_q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL to_cpu_q got %h exp all-ones", cpu_q); end
        // Late ack during resync, plus a new CPU request that must wait it out
        mem_ack = 1'b1; cpu_addr = 27'h0000400;
        cpu_req = ~cpu_req;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || cpu_ack !== 1'b1) begin errors++; $display("FAIL to_resync edge %0d got %0b %0b exp 1 1", i, mem_req, cpu_ack); end
        end
        tick();
        checks++; if (mem_req !== 1'b0 || mem_addr !== 27'h0000400) begin errors++; $display("FAIL to_regrant got %0b %h exp 0 400", mem_req, mem_addr); end
        mem_q = 64'hFEED_FACE_0BAD_F00D; mem_ack = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0 || cpu_q !== 64'hFEED_FACE_0BAD_F00D) begin errors++; $display("FAIL to_recover got %0b %h exp 0 feedface0badf00d", cpu_ack, cpu_q); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b exp 1", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_loader_write();
        test_absorb();
        test_mode_switch();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/sdram_ch3_arbiter.md
# sdram_ch3_arbiter

Arbitrates SDRAM channel 3 between the ROM loader (write path during download) and the F2 CPU (read/write path during play). It uses toggle-style req/ack handshakes on both client ports and on the memory port, and it latches each transaction's request fields. Mode switches only occur at transaction boundaries, and requests from the inactive client are absorbed safely. The block sits between `rom_loader` / `F2` and the `sdram` controller, in the SDRAM clock domain.

## Interface
Parameters:
- `ADDR_W`, 27, address width.
- `TIMEOUT`, 4096, max cycles waiting on memory ack; 0 disables the watchdog.
- `RESYNC_CYCLES`, 16, cycles spent re-aligning `mem_req` to `mem_ack` after reset or timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: SDRAM clock.
- `reset_n` in 1: async active-low reset.
- `loader_busy` in 1: 1 selects loader mode, 0 selects CPU mode.
- `ldr_addr` in ADDR_W, `ldr_din` in 16, `ldr_be` in 2, `ldr_rnw` in 1: loader request fields.
- `ldr_req` in 1: loader request toggle.
- `ldr_ack` out 1: loader ack toggle.
- `cpu_addr` in ADDR_W, `cpu_din` in 16, `cpu_be` in 2, `cpu_rnw` in 1: CPU request fields.
- `cpu_req` in 1: CPU request toggle.
- `cpu_ack` out 1: CPU ack toggle.
- `cpu_q` out 64: CPU read data.
- `mem_addr` out ADDR_W, `mem_din` out 16, `mem_be` out 2, `mem_rnw` out 1: latched fields to the sdram controller.
- `mem_req` out 1: memory request toggle.
- `mem_ack` in 1: memory ack toggle.
- `mem_q` in 64: memory read data.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- A client is pending when `req != ack`. Memory is busy when `mem_req != mem_ack`.
- `mode` register: 0 = CPU, 1 = loader. `mode` loads from `loader_busy` only in IDLE.
- States: RESYNC, IDLE, WAIT.
- RESYNC:
  - Each cycle, `mem_req <= mem_ack`. Client requests are not serviced.
  - After RESYNC_CYCLES cycles, go to IDLE.
- IDLE:
  - `mode <= loader_busy`.
  - If the client selected by `loader_busy` is pending: latch its addr/din/be/rnw into `mem_*`, toggle `mem_req`, record the owner, clear the watchdog counter, go to WAIT.
  - The non-selected client, if pending, is absorbed: its ack toggles, there is no memory access, and `cpu_q` is unchanged.
- WAIT:
  - `loader_busy` changes are ignored.
  - If `mem_ack == mem_req`: if the owner is the CPU and the access is a read, `cpu_q <= mem_q`; toggle the owner's ack; go to IDLE.
  - Else, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: set `timeout_err`, set `cpu_q <= 64'hFFFF_FFFF_FFFF_FFFF` if the owner is the CPU, toggle the owner's ack, go to RESYNC.
  - The non-owner client stays pending. It is absorbed or served only after return to IDLE.
- Writes (`rnw=0`) never update `cpu_q`.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide, saturating.
- Only one transaction is outstanding at a time; there is no queuing beyond the one pending toggle per client.

## Timing
- All outputs are registered.
- Reset values: `mem_req=0`, `ldr_ack=0`, `cpu_ack=0`, `cpu_q=0`, `mem_addr=0`, `mem_din=0`, `mem_be=0`, `mem_rnw=1`, `timeout_err=0`, `mode=0`, state=RESYNC.
- Reset asserted mid-WAIT: the transaction is abandoned immediately and no client ack is issued. RESYNC then absorbs the late memory ack.
- Grant: a client toggles req before edge N (in IDLE) → `mem_*` and the `mem_req` toggle are visible after edge N.
- Completion: `mem_ack` matches before edge M → owner ack toggles and `cpu_q` updates after edge M. The minimum client-visible latency is 2 edges.
- Absorb: a pending non-selected client in IDLE → its ack toggles after the next edge.
- After completion, one IDLE cycle always occurs before the next grant, so back-to-back throughput is mem latency + 1.
- Simultaneous pending loader and CPU in IDLE: the one matching `loader_busy` is granted; the other is absorbed on the same edge.
- Toggle wrap is inherent: there are no counters on the handshakes.

## Test plan
- **Reset/resync:** release `reset_n` with `mem_ack=1`. Required: `mem_req` reaches 1 within 1 cycle, and no client is granted until 16 cycles have elapsed.
- **CPU read:** `loader_busy=0`, `cpu_addr=27'h0123456`, `rnw=1`, toggle `cpu_req`; memory acks 5 cycles later with `mem_q=64'hDEADBEEF_CAFEF00D`. Required: `mem_addr=27'h0123456`; `cpu_ack` toggles and `cpu_q=64'hDEADBEEF_CAFEF00D` on the ack edge.
- **Loader write:** `loader_busy=1`, `din=16'hA55A`, `be=2'b01`, `rnw=0`. Required: `mem_din=16'hA55A`, `mem_be=2'b01`; `ldr_ack` toggles on completion; `cpu_q` is unchanged.
- **Absorb:** `loader_busy=1`, toggle `cpu_req`. Required: `cpu_ack` toggles 1 cycle later, `mem_req` is unchanged, and `cpu_q` is unchanged.
- **Mode switch mid-transaction:** CPU read in WAIT, `loader_busy` rises, and a loader req arrives. Required: the CPU transaction completes first, the loader is granted 1 cycle after IDLE, and the loader's `mem_addr` appears then.
- **Timeout:** TIMEOUT=8, CPU read with no `mem_ack`. Required: after 8 WAIT cycles, `timeout_err=1`, `cpu_ack` toggles, `cpu_q` is all-ones, and the state is RESYNC. A late `mem_ack` during RESYNC produces no client ack.
